// File: rtl/pattern_check_64.sv
// Checks a 64-bit beat stream (two 32-bit generator words per beat, low half first)
// against a selectable pattern generator; counts mismatched words and captures the first failure.
module pattern_check_64 #(
  parameter int BEAT_W = 32
) (
  input  logic              okClk,
  input  logic              reset,
  input  logic              reset_pattern,
  input  logic [1:0]        mode,
  input  logic [31:0]       seed,
  input  logic [BEAT_W-1:0] term_beats,
  input  logic [63:0]       data_in,
  input  logic              data_valid,
  output logic [31:0]       error_count,
  output logic [BEAT_W-1:0] beat_count,
  output logic              err_flag,
  output logic [BEAT_W-1:0] first_err_index,
  output logic [63:0]       first_err_data,
  output logic [63:0]       first_err_exp,
  output logic              done
);

  typedef enum logic [1:0] {S_ARMED, S_CHECK, S_DONE} state_t;

  state_t            state_q;
  logic [31:0]       g_q;
  logic [1:0]        mode_q;
  logic [31:0]       err_cnt_q;
  logic [BEAT_W-1:0] beat_q;
  logic              flag_q;
  logic [BEAT_W-1:0] fidx_q;
  logic [63:0]       fdata_q;
  logic [63:0]       fexp_q;
  logic              done_q;

  function automatic logic [31:0] gen_next(input logic [31:0] g, input logic [1:0] m);
    case (m)
      2'd0:    gen_next = g + 32'd1;
      2'd1:    gen_next = {g[30:0], g[31]};
      2'd2:    gen_next = {g[30:0], g[31] ^ g[21] ^ g[1] ^ g[0]};
      default: gen_next = g;
    endcase
  endfunction

  logic [31:0]       g1;
  logic [31:0]       g_d;
  logic [63:0]       exp_beat;
  logic              miss_lo, miss_hi;
  logic [32:0]       err_sum;
  logic [31:0]       err_cnt_d;
  logic [BEAT_W-1:0] beat_d;
  logic [31:0]       seed_load;
  logic              take;

  always_comb begin
    g1        = gen_next(g_q, mode_q);
    g_d       = gen_next(g1, mode_q);
    exp_beat  = {g1, g_q};
    miss_lo   = data_in[31:0]  != exp_beat[31:0];
    miss_hi   = data_in[63:32] != exp_beat[63:32];
    err_sum   = {1'b0, err_cnt_q} + {32'd0, miss_lo} + {32'd0, miss_hi};
    // Sum carries out only past 0xFFFFFFFF, so clamp there.
    err_cnt_d = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
    beat_d    = beat_q + 1'b1;
    // A zero seed would lock up rotate and LFSR modes.
    seed_load = (seed == 32'd0 && (mode == 2'd1 || mode == 2'd2)) ? 32'd1 : seed;
    take      = data_valid && (state_q != S_DONE);
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      state_q   <= S_ARMED;
      g_q       <= '0;
      mode_q    <= '0;
      err_cnt_q <= '0;
      beat_q    <= '0;
      flag_q    <= 1'b0;
      fidx_q    <= '0;
      fdata_q   <= '0;
      fexp_q    <= '0;
      done_q    <= 1'b0;
    end else if (reset_pattern) begin
      state_q <= S_ARMED;
      g_q     <= seed_load;
      mode_q  <= mode;
      beat_q  <= '0;
      done_q  <= 1'b0;
    end else if (take) begin
      g_q       <= g_d;
      beat_q    <= beat_d;
      err_cnt_q <= err_cnt_d;
      if ((miss_lo || miss_hi) && !flag_q) begin
        flag_q  <= 1'b1;
        fidx_q  <= beat_q;
        fdata_q <= data_in;
        fexp_q  <= exp_beat;
      end
      if (term_beats != '0 && beat_d == term_beats) begin
        state_q <= S_DONE;
        done_q  <= 1'b1;
      end else begin
        state_q <= S_CHECK;
      end
    end
  end

  assign error_count     = err_cnt_q;
  assign beat_count      = beat_q;
  assign err_flag        = flag_q;
  assign first_err_index = fidx_q;
  assign first_err_data  = fdata_q;
  assign first_err_exp   = fexp_q;
  assign done            = done_q;

endmodule

// File: tb/tb_pattern_check_64.sv
// Bench for pattern_check_64: vector table, hand sequences, then random traffic
// against a word-stream reference model.
module tb_pattern_check_64;
  localparam int BW = 8;

  logic          okClk = 1'b0;
  logic          reset, reset_pattern, data_valid;
  logic [1:0]    mode;
  logic [31:0]   seed;
  logic [BW-1:0] term_beats;
  logic [63:0]   data_in;
  logic [31:0]   error_count;
  logic [BW-1:0] beat_count, first_err_index;
  logic          err_flag, done;
  logic [63:0]   first_err_data, first_err_exp;

  pattern_check_64 #(.BEAT_W(BW)) dut (
    .okClk(okClk), .reset(reset), .reset_pattern(reset_pattern), .mode(mode), .seed(seed),
    .term_beats(term_beats), .data_in(data_in), .data_valid(data_valid),
    .error_count(error_count), .beat_count(beat_count), .err_flag(err_flag),
    .first_err_index(first_err_index), .first_err_data(first_err_data),
    .first_err_exp(first_err_exp), .done(done));

  always #5 okClk = ~okClk;

  int checks = 0, failures = 0;

  // Reference model: the generator is an endless word stream; each beat consumes two words.
  logic [31:0]   m_word;
  logic [1:0]    m_mode;
  longint        m_err;
  int            m_cnt;
  bit            m_flag, m_done;
  logic [BW-1:0] m_fidx;
  logic [63:0]   m_fdata, m_fexp;

  function automatic logic [31:0] succ(input logic [31:0] w, input logic [1:0] m);
    case (m)
      2'd0:    return w + 1;
      2'd1:    return (w << 1) | (w >> 31);
      2'd2:    return (w << 1) | 32'(w[31] ^ w[21] ^ w[1] ^ w[0]);
      default: return w;
    endcase
  endfunction

  function automatic logic [63:0] peek_beat();
    return {succ(m_word, m_mode), m_word};
  endfunction

  task automatic model_step(input logic r, input logic p, input logic v, input logic [63:0] d);
    logic [63:0] e;
    int nbad;
    if (r) begin
      m_word = 0; m_mode = 0; m_err = 0; m_cnt = 0; m_flag = 0; m_done = 0;
      m_fidx = 0; m_fdata = 0; m_fexp = 0;
    end else if (p) begin
      m_mode = mode;
      m_word = (seed == 0 && (mode == 1 || mode == 2)) ? 32'd1 : seed;
      m_cnt = 0; m_done = 0;
    end else if (v && !m_done) begin
      e = peek_beat();
      m_word = succ(e[63:32], m_mode);
      nbad = int'(d[31:0] != e[31:0]) + int'(d[63:32] != e[63:32]);
      if (nbad != 0 && !m_flag) begin
        m_flag = 1; m_fidx = BW'(m_cnt); m_fdata = d; m_fexp = e;
      end
      m_err = m_err + nbad;
      if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
      m_cnt = (m_cnt + 1) % (1 << BW);
      if (term_beats != 0 && m_cnt == int'(term_beats)) m_done = 1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("error_count", 64'(error_count), 64'(m_err));
    chk("beat_count", 64'(beat_count), 64'(m_cnt));
    chk("err_flag", 64'(err_flag), 64'(m_flag));
    chk("done", 64'(done), 64'(m_done));
    chk("first_err_index", 64'(first_err_index), 64'(m_fidx));
    chk("first_err_data", first_err_data, m_fdata);
    chk("first_err_exp", first_err_exp, m_fexp);
  endtask

  task automatic step(input logic r, input logic p, input logic v, input logic [63:0] d);
    reset = r; reset_pattern = p; data_valid = v; data_in = d;
    @(posedge okClk);
    model_step(r, p, v, d);
    #1;
    chk_model();
  endtask

  typedef struct {
    logic          rst, rp;
    logic [1:0]    md;
    logic [31:0]   sd;
    logic [BW-1:0] tm;
    logic          vld;
    logic [63:0]   d;
    logic [31:0]   e_err;
    logic [BW-1:0] e_beat;
    logic          e_flag, e_done;
  } vec_t;

  vec_t tbl[18];

  initial begin
    reset = 1; reset_pattern = 0; data_valid = 0; data_in = 0;
    mode = 0; seed = 0; term_beats = 0;

    tbl[0]  = '{1, 0, 0, 32'h0,        0, 0, 64'h0,                   0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 32'h10,       2, 0, 64'h0,                   0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 32'h10,       2, 1, 64'h00000011_00000010,   0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 32'h10,       2, 1, 64'h00000013_00000012,   0, 2, 0, 1};
    tbl[4]  = '{0, 0, 0, 32'h10,       2, 1, 64'hDEADBEEF_DEADBEEF,   0, 2, 0, 1};
    tbl[5]  = '{0, 1, 0, 32'h0,        0, 0, 64'h0,                   0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 32'h0,        0, 1, 64'h00000001_00000000,   0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 32'h0,        0, 1, 64'h00000003_000000FF,   1, 2, 1, 0};
    tbl[8]  = '{0, 1, 2, 32'h0,        0, 0, 64'h0,                   1, 0, 1, 0};
    tbl[9]  = '{0, 0, 2, 32'h0,        0, 1, 64'h00000003_00000001,   1, 1, 1, 0};
    tbl[10] = '{0, 0, 2, 32'h0,        0, 1, 64'h0000000D_00000006,   1, 2, 1, 0};
    tbl[11] = '{0, 1, 3, 32'hA5A5A5A5, 0, 1, 64'h0,                   1, 0, 1, 0};
    tbl[12] = '{0, 0, 3, 32'hA5A5A5A5, 0, 1, 64'hA5A5A5A5_A5A5A5A5,   1, 1, 1, 0};
    tbl[13] = '{0, 1, 1, 32'h0,        3, 0, 64'h0,                   1, 0, 1, 0};
    tbl[14] = '{0, 0, 1, 32'h0,        3, 1, 64'h00000002_00000001,   1, 1, 1, 0};
    tbl[15] = '{0, 0, 1, 32'h0,        3, 1, 64'h00000008_00000004,   1, 2, 1, 0};
    tbl[16] = '{0, 0, 1, 32'h0,        3, 1, 64'h00000021_00000010,   2, 3, 1, 1};
    tbl[17] = '{1, 0, 1, 32'h0,        3, 1, 64'h00000080_00000040,   0, 0, 0, 0};

    for (int i = 0; i < 18; i++) begin
      mode = tbl[i].md; seed = tbl[i].sd; term_beats = tbl[i].tm;
      step(tbl[i].rst, tbl[i].rp, tbl[i].vld, tbl[i].d);
      chk($sformatf("tbl%0d.err", i), 64'(error_count), 64'(tbl[i].e_err));
      chk($sformatf("tbl%0d.beat", i), 64'(beat_count), 64'(tbl[i].e_beat));
      chk($sformatf("tbl%0d.flag", i), 64'(err_flag), 64'(tbl[i].e_flag));
      chk($sformatf("tbl%0d.done", i), 64'(done), 64'(tbl[i].e_done));
      if (i == 7) begin
        chk("first_idx_const", 64'(first_err_index), 64'd1);
        chk("first_exp_const", first_err_exp, 64'h00000003_00000002);
        chk("first_dat_const", first_err_data, 64'h00000003_000000FF);
      end
    end

    // Saturation: preload the counter just below the top, then two-word errors.
    mode = 0; seed = 0; term_beats = 0;
    step(0, 1, 0, 64'h0);
    force dut.err_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.err_cnt_q;
    m_err = 64'hFFFF_FFFE;
    step(0, 0, 1, ~peek_beat());
    chk("sat_const", 64'(error_count), 64'hFFFF_FFFF);
    step(0, 0, 1, ~peek_beat());
    chk("sat_hold", 64'(error_count), 64'hFFFF_FFFF);

    // term_beats = 1 goes straight from the first beat to done.
    step(1, 0, 0, 64'h0);
    seed = 5; term_beats = 1;
    step(0, 1, 0, 64'h0);
    step(0, 0, 1, 64'h00000006_00000005);
    chk("term1_done", 64'(done), 64'd1);
    step(0, 0, 1, peek_beat());
    chk("term1_cnt", 64'(beat_count), 64'd1);

    // beat_count wrap with unlimited term.
    term_beats = 0; seed = 32'h1234;
    step(0, 1, 0, 64'h0);
    for (int i = 0; i < 257; i++) step(0, 0, 1, peek_beat());
    chk("wrap_cnt", 64'(beat_count), 64'd1);
    chk("wrap_err", 64'(error_count), 64'd0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [63:0] d;
      logic rr, pp, vv;
      r = $urandom_range(0, 99);
      rr = (r < 2);
      pp = (r >= 2 && r < 8);
      if (pp) begin
        mode = 2'($urandom_range(0, 3));
        seed = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
        term_beats = BW'($urandom_range(0, 12));
      end
      vv = ($urandom_range(0, 9) < 7);
      d = peek_beat();
      if ($urandom_range(0, 9) < 2) d = d ^ (64'd1 << $urandom_range(0, 63));
      step(rr, pp, vv, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
